// File: rtl/calibration_pkg.sv
// calibration_pkg
// Shared types for the binary-coded LED calibration sequencer:
//   calib_state_t : sequencer FSM state encoding (exported on the state port)
//   upd_mode_t    : how a code-RAM entry is updated at a sample point
//   next_good     : good-bit update rule shared by the RMW pipeline
package calibration_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQ_PATTERN = 3'd1,
    WAIT_SETTLE = 3'd2,
    WAIT_NFRAME = 3'd3,
    CAPTURE     = 3'd4,
    DONE        = 3'd5
  } calib_state_t;

  // UPD_INIT starts a fresh code (first bit-plane), UPD_SHIFT appends to it.
  typedef enum logic {
    UPD_INIT  = 1'b0,
    UPD_SHIFT = 1'b1
  } upd_mode_t;

  // A pixel stays good only while exactly one of its detect bits is set.
  function automatic logic next_good(upd_mode_t mode, logic old_good,
                                     logic d0, logic d1);
    return (d0 ^ d1) & ((mode == UPD_INIT) | old_good);
  endfunction

endpackage

// File: rtl/calib_code_ram.sv
// calib_code_ram
// Per-pixel {good, code} storage with a 2-cycle read-modify-write pipeline
// for capture updates and a 2-cycle external read port.
// Ports:
//   clk_pixel, rst            : clock, synchronous active-high reset
//   samp_valid/addr/mode      : capture sample point (read at cycle 0, write at cycle 2)
//   detect_0, detect_1        : detect bits for the sample point
//   rd_accept, rd_addr        : accepted external read request
//   rd_valid, rd_code, rd_good: external read result, 2 cycles after accept
//   good_lost                 : (CALIB_CONFLICT_COUNT_EN only) a pixel's good bit fell 1->0
// Optional macro: CALIB_CONFLICT_COUNT_EN
module calib_code_ram
  import calibration_pkg::*;
#(
  parameter int CODE_WIDTH = 10,
  parameter int DEPTH      = 3600,
  parameter int AW         = 12
) (
  input  logic                  clk_pixel,
  input  logic                  rst,
  input  logic                  samp_valid,
  input  logic [AW-1:0]         samp_addr,
  input  upd_mode_t             samp_mode,
  input  logic                  detect_0,
  input  logic                  detect_1,
  input  logic                  rd_accept,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_valid,
  output logic [CODE_WIDTH-1:0] rd_code,
  output logic                  rd_good
`ifdef CALIB_CONFLICT_COUNT_EN
  ,
  output logic                  good_lost
`endif
);

  localparam int EW = CODE_WIDTH + 1;

  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         q1, q2;
  logic [AW-1:0]         raddr;
  logic [AW-1:0]         s1_addr, s2_addr;
  logic                  s1_valid, s2_valid;
  logic                  s1_d0, s1_d1, s2_d0, s2_d1;
  upd_mode_t             s1_mode, s2_mode;
  logic                  rd_v1;
  logic                  new_good;
  logic [CODE_WIDTH-1:0] new_code;

  // Capture samples and external reads never overlap: the read port is
  // closed while capturing, so one RAM read port serves both.
  assign raddr = samp_valid ? samp_addr : rd_addr;

  always_ff @(posedge clk_pixel) begin
    q1 <= mem[raddr];
    q2 <= q1;
    if (s2_valid) mem[s2_addr] <= {new_good, new_code};
  end

  always_ff @(posedge clk_pixel) begin
    s1_addr <= samp_addr;
    s1_d0   <= detect_0;
    s1_d1   <= detect_1;
    s1_mode <= samp_mode;
    s2_addr <= s1_addr;
    s2_d0   <= s1_d0;
    s2_d1   <= s1_d1;
    s2_mode <= s1_mode;
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rd_v1    <= 1'b0;
      rd_valid <= 1'b0;
      rd_code  <= '0;
      rd_good  <= 1'b0;
    end else begin
      s1_valid <= samp_valid;
      s2_valid <= s1_valid;
      rd_v1    <= rd_accept;
      rd_valid <= rd_v1;
      if (rd_v1) {rd_good, rd_code} <= q1;
    end
  end

  always_comb begin
    new_good = next_good(s2_mode, q2[CODE_WIDTH], s2_d0, s2_d1);
    if (s2_mode == UPD_INIT) new_code = CODE_WIDTH'(s2_d1);
    else                     new_code = CODE_WIDTH'({q2[CODE_WIDTH-1:0], s2_d1});
  end

`ifdef CALIB_CONFLICT_COUNT_EN
  // First plane has no prior good bit in this run, so treat it as 1.
  assign good_lost = s2_valid & ~new_good & ((s2_mode == UPD_INIT) | q2[CODE_WIDTH]);
`endif

endmodule

// File: rtl/calibration_sequencer.sv
// calibration_sequencer
// Runs a complete binary-coded LED calibration on one start edge: for each
// bit-plane (MSB first) it requests the LED pattern, waits for settling,
// captures one frame and shifts each sampled pixel's detect bit into the
// per-pixel code RAM. Finished codes are read back through the read port.
// Ports:
//   clk_pixel, rst                  : pixel clock, synchronous active-high reset
//   start, abort                    : run launch (rising edge), return to IDLE (level)
//   pattern_req, bit_idx, pattern_ack : LED strand driver handshake
//   hcount_in, vcount_in, new_frame_in, detect_0, detect_1 : camera pipeline
//   state, busy, done               : status
//   rd_req_in, rd_addr_in, rd_ready_out, rd_valid_out, rd_code_out, rd_good_out : code read port
//   conflict_count_out              : (CALIB_CONFLICT_COUNT_EN only) pixels that lost good
// Optional macro: CALIB_CONFLICT_COUNT_EN
//
// state       | meaning
// IDLE        | waiting for a start edge
// REQ_PATTERN | asking the driver for bit-plane bit_idx
// WAIT_SETTLE | pattern shown, waiting SETTLE_CYCLES for the scene to settle
// WAIT_NFRAME | waiting for the start of a full frame
// CAPTURE     | sampling one frame into the code RAM
// DONE        | all bit-planes captured, codes readable
module calibration_sequencer
  import calibration_pkg::*;
#(
  parameter int CODE_WIDTH      = 10,
  parameter int SETTLE_CYCLES   = 10000000,
  parameter int ACTIVE_H_PIXELS = 320,
  parameter int ACTIVE_LINES    = 180,
  parameter int DS_SHIFT        = 2,
  localparam int DEPTH = (ACTIVE_H_PIXELS >> DS_SHIFT) * (ACTIVE_LINES >> DS_SHIFT),
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1
) (
  input  logic                  clk_pixel,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  pattern_req,
  output logic [BW-1:0]         bit_idx,
  input  logic                  pattern_ack,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  new_frame_in,
  input  logic                  detect_0,
  input  logic                  detect_1,
  output calib_state_t          state,
  output logic                  busy,
  output logic                  done,
  input  logic                  rd_req_in,
  input  logic [AW-1:0]         rd_addr_in,
  output logic                  rd_ready_out,
  output logic                  rd_valid_out,
  output logic [CODE_WIDTH-1:0] rd_code_out,
  output logic                  rd_good_out
`ifdef CALIB_CONFLICT_COUNT_EN
  ,
  output logic [AW:0]           conflict_count_out
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(CODE_WIDTH - 1);
  localparam logic [10:0]   H_LIM       = 11'(ACTIVE_H_PIXELS);
  localparam logic [9:0]    V_LIM       = 10'(ACTIVE_LINES);
  localparam int            H_DS        = ACTIVE_H_PIXELS >> DS_SHIFT;

  calib_state_t  state_q, state_n;
  logic [BW-1:0] bit_q, bit_n;
  logic [SW-1:0] cnt_q, cnt_n;
  logic          start_d;
  logic          start_edge, start_go;
  logic          sample_pt, samp_valid;
  logic [31:0]   h_ds, v_ds;
  logic [AW-1:0] samp_addr;

  assign start_edge = start & ~start_d;
  assign start_go   = start_edge & ~abort & ((state_q == IDLE) | (state_q == DONE));

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      cnt_q   <= '0;
      start_d <= 1'b0;
    end else begin
      state_q <= state_n;
      bit_q   <= bit_n;
      cnt_q   <= cnt_n;
      start_d <= start;
    end
  end

  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    cnt_n   = cnt_q;
    if (abort) begin
      state_n = IDLE;
      bit_n   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            state_n = REQ_PATTERN;
            bit_n   = '0;
          end
        end
        REQ_PATTERN: begin
          if (pattern_ack) begin
            state_n = WAIT_SETTLE;
            cnt_n   = '0;
          end
        end
        WAIT_SETTLE: begin
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == SETTLE_LAST) state_n = WAIT_NFRAME;
        end
        WAIT_NFRAME: begin
          if (new_frame_in) state_n = CAPTURE;
        end
        CAPTURE: begin
          if (new_frame_in) begin
            if (bit_q == BIT_LAST) begin
              state_n = DONE;
            end else begin
              state_n = REQ_PATTERN;
              bit_n   = bit_q + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // The pattern must stay displayed from the request until the frame is captured.
  assign pattern_req  = (state_q == REQ_PATTERN) | (state_q == WAIT_SETTLE) |
                        (state_q == WAIT_NFRAME) | (state_q == CAPTURE);
  assign busy         = (state_q != IDLE) & (state_q != DONE);
  assign done         = (state_q == DONE);
  assign state        = state_q;
  assign bit_idx      = bit_q;
  assign rd_ready_out = (state_q != CAPTURE);

  assign sample_pt  = (hcount_in < H_LIM) & (vcount_in < V_LIM) &
                      (hcount_in[DS_SHIFT-1:0] == '0) & (vcount_in[DS_SHIFT-1:0] == '0);
  assign samp_valid = (state_q == CAPTURE) & sample_pt;
  assign h_ds       = 32'(hcount_in >> DS_SHIFT);
  assign v_ds       = 32'(vcount_in >> DS_SHIFT);
  assign samp_addr  = AW'(h_ds + 32'(H_DS) * v_ds);

`ifdef CALIB_CONFLICT_COUNT_EN
  logic good_lost;
`endif

  calib_code_ram #(
    .CODE_WIDTH (CODE_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk_pixel  (clk_pixel),
    .rst        (rst),
    .samp_valid (samp_valid),
    .samp_addr  (samp_addr),
    .samp_mode  ((bit_q == '0) ? UPD_INIT : UPD_SHIFT),
    .detect_0   (detect_0),
    .detect_1   (detect_1),
    .rd_accept  (rd_req_in & rd_ready_out),
    .rd_addr    (rd_addr_in),
    .rd_valid   (rd_valid_out),
    .rd_code    (rd_code_out),
    .rd_good    (rd_good_out)
`ifdef CALIB_CONFLICT_COUNT_EN
    ,
    .good_lost  (good_lost)
`endif
  );

`ifdef CALIB_CONFLICT_COUNT_EN
  always_ff @(posedge clk_pixel) begin
    if (rst || abort || start_go)
      conflict_count_out <= '0;
    else if (good_lost && (conflict_count_out != (AW+1)'(DEPTH)))
      conflict_count_out <= conflict_count_out + 1'b1;
  end
`endif

endmodule

// File: tb/tb_calibration_sequencer.sv
// tb_calibration_sequencer
// Directed bench for calibration_sequencer with H=16, V=8, DS_SHIFT=2,
// CODE_WIDTH=3, SETTLE_CYCLES=4 (DEPTH=8). Sampled pixel p is driven so that
// its finished code equals p; pixel 2 can be given a bit-plane-1 conflict.
module tb_calibration_sequencer;
  import calibration_pkg::*;

  logic         clk_pixel = 1'b0;
  logic         rst, start, abort, pattern_ack;
  logic         pattern_req;
  logic [1:0]   bit_idx;
  logic [10:0]  hcount_in;
  logic [9:0]   vcount_in;
  logic         new_frame_in, detect_0, detect_1;
  calib_state_t state;
  logic         busy, done;
  logic         rd_req_in;
  logic [2:0]   rd_addr_in;
  logic         rd_ready_out, rd_valid_out, rd_good_out;
  logic [2:0]   rd_code_out;
`ifdef CALIB_CONFLICT_COUNT_EN
  logic [3:0]   conflict_count_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_pixel = ~clk_pixel;

  calibration_sequencer #(
    .CODE_WIDTH      (3),
    .SETTLE_CYCLES   (4),
    .ACTIVE_H_PIXELS (16),
    .ACTIVE_LINES    (8),
    .DS_SHIFT        (2)
  ) dut (
    .clk_pixel    (clk_pixel),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pattern_req  (pattern_req),
    .bit_idx      (bit_idx),
    .pattern_ack  (pattern_ack),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .new_frame_in (new_frame_in),
    .detect_0     (detect_0),
    .detect_1     (detect_1),
    .state        (state),
    .busy         (busy),
    .done         (done),
    .rd_req_in    (rd_req_in),
    .rd_addr_in   (rd_addr_in),
    .rd_ready_out (rd_ready_out),
    .rd_valid_out (rd_valid_out),
    .rd_code_out  (rd_code_out),
    .rd_good_out  (rd_good_out)
`ifdef CALIB_CONFLICT_COUNT_EN
    ,
    .conflict_count_out (conflict_count_out)
`endif
  );

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic wait_state(input calib_state_t tgt, input int budget, input string name);
    for (int n = 0; n < budget && state != tgt; n++) tick();
    n_checks++;
    if (state !== tgt) begin
      n_fail++;
      $display("FAIL %s timeout: state %0d, expected %0d", name, state, tgt);
    end
  endtask

  task automatic pulse_nf();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic scan_frame(input int plane, input bit conflict);
    logic [2:0] pv;
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < 16; h++) begin
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        if ((h % 4 == 0) && (v % 4 == 0)) begin
          pv = 3'(h / 4 + 4 * (v / 4));
          detect_1 = pv[2 - plane];
          detect_0 = ~pv[2 - plane];
          if (conflict && pv == 3'd2 && plane == 1) begin
            detect_0 = 1'b1;
            detect_1 = 1'b1;
          end
        end else begin
          detect_0 = 1'b0;
          detect_1 = 1'b0;
        end
        tick();
      end
    end
    hcount_in = 11'd500;
    vcount_in = 10'd500;
    detect_0  = 1'b0;
    detect_1  = 1'b0;
  endtask

  task automatic run_calibration(input bit conflict, input bit hold_start);
    pattern_ack = 1'b1;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    n_checks++;
    if (state !== REQ_PATTERN || bit_idx !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL run_start: state %0d bit %0d done %0b, expected 1 0 0", state, bit_idx, done);
    end
    for (int p = 0; p < 3; p++) begin
      wait_state(WAIT_NFRAME, 50, "run_wait_nframe");
      pulse_nf();
      n_checks++;
      if (state !== CAPTURE || bit_idx !== 2'(p)) begin
        n_fail++;
        $display("FAIL run_capture: state %0d bit %0d, expected 4 %0d", state, bit_idx, p);
      end
      scan_frame(p, conflict);
      pulse_nf();
    end
    n_checks++;
    if (state !== DONE || done !== 1'b1 || pattern_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_done: state %0d done %0b req %0b busy %0b, expected 5 1 0 0",
               state, done, pattern_req, busy);
    end
  endtask

  task automatic read_pixel(input logic [2:0] addr, input logic [2:0] exp_code, input logic exp_good);
    rd_req_in  = 1'b1;
    rd_addr_in = addr;
    tick();
    rd_req_in = 1'b0;
    n_checks++;
    if (rd_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL read_early_valid addr %0d: valid %0b, expected 0", addr, rd_valid_out);
    end
    tick();
    n_checks++;
    if (rd_valid_out !== 1'b1 || rd_code_out !== exp_code || rd_good_out !== exp_good) begin
      n_fail++;
      $display("FAIL read_data addr %0d: valid %0b code %0b good %0b, expected 1 %0b %0b",
               addr, rd_valid_out, rd_code_out, rd_good_out, exp_code, exp_good);
    end
    tick();
    n_checks++;
    if (rd_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL read_pulse addr %0d: valid %0b, expected 0", addr, rd_valid_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state !== IDLE || pattern_req !== 1'b0 || bit_idx !== 2'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: state %0d req %0b bit %0d done %0b busy %0b, expected all 0",
               state, pattern_req, bit_idx, done, busy);
    end
    n_checks++;
    if (rd_valid_out !== 1'b0 || rd_code_out !== 3'd0 || rd_good_out !== 1'b0 || rd_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_read: valid %0b code %0b good %0b ready %0b, expected 0 0 0 1",
               rd_valid_out, rd_code_out, rd_good_out, rd_ready_out);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_release: state %0d, expected 0", state);
    end
  endtask

  task automatic test_full_run();
    run_calibration(1'b0, 1'b0);
    read_pixel(3'd5, 3'b101, 1'b1);
    read_pixel(3'd0, 3'b000, 1'b1);
    read_pixel(3'd6, 3'b110, 1'b1);
`ifdef CALIB_CONFLICT_COUNT_EN
    n_checks++;
    if (conflict_count_out !== 4'd0) begin
      n_fail++;
      $display("FAIL clean_count: got %0d, expected 0", conflict_count_out);
    end
`endif
  endtask

  task automatic test_conflict();
    run_calibration(1'b1, 1'b0);
    read_pixel(3'd2, 3'b010, 1'b0);
    read_pixel(3'd3, 3'b011, 1'b1);
`ifdef CALIB_CONFLICT_COUNT_EN
    n_checks++;
    if (conflict_count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL conflict_count: got %0d, expected 1", conflict_count_out);
    end
`endif
  endtask

  task automatic test_handshake();
    int n;
    pattern_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (state !== REQ_PATTERN || pattern_req !== 1'b1) begin
        n_fail++;
        $display("FAIL hs_hold cycle %0d: state %0d req %0b, expected 1 1", i, state, pattern_req);
      end
    end
    pattern_ack = 1'b1;
    tick();
    n_checks++;
    if (state !== WAIT_SETTLE || pattern_req !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_settle_entry: state %0d req %0b, expected 2 1", state, pattern_req);
    end
    n = 0;
    while (state == WAIT_SETTLE && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 4 || state !== WAIT_NFRAME) begin
      n_fail++;
      $display("FAIL hs_settle_len: %0d cycles then state %0d, expected 4 then 3", n, state);
    end
  endtask

  task automatic test_busy_ignore();
    pulse_nf();
    scan_frame(0, 1'b0);
    pulse_nf();
    wait_state(WAIT_NFRAME, 50, "busy_wait_nframe");
    pulse_nf();
    n_checks++;
    if (state !== CAPTURE || bit_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL busy_capture: state %0d bit %0d, expected 4 1", state, bit_idx);
    end
    rd_req_in  = 1'b1;
    rd_addr_in = 3'd5;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) rd_req_in = 1'b0;
      n_checks++;
      if (rd_ready_out !== 1'b0 || rd_valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL capture_read cycle %0d: ready %0b valid %0b, expected 0 0", i, rd_ready_out, rd_valid_out);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (state !== CAPTURE || bit_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL busy_start: state %0d bit %0d, expected 4 1", state, bit_idx);
    end
  endtask

  task automatic test_abort();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if (state !== IDLE || bit_idx !== 2'd0 || pattern_req !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: state %0d bit %0d req %0b done %0b, expected 0 0 0 0",
               state, bit_idx, pattern_req, done);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (state !== REQ_PATTERN || bit_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_restart: state %0d bit %0d, expected 1 0", state, bit_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_start_held();
    run_calibration(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (state !== DONE || done !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start: state %0d done %0b, expected 5 1", state, done);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (state !== REQ_PATTERN || done !== 1'b0 || bit_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL fresh_edge: state %0d done %0b bit %0d, expected 1 0 0", state, done, bit_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    pattern_ack  = 1'b0;
    hcount_in    = 11'd500;
    vcount_in    = 10'd500;
    new_frame_in = 1'b0;
    detect_0     = 1'b0;
    detect_1     = 1'b0;
    rd_req_in    = 1'b0;
    rd_addr_in   = 3'd0;
    test_reset();
    test_full_run();
    test_conflict();
    test_handshake();
    test_busy_ignore();
    test_abort();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
